frame_scan_sequencer: RTL and testbench

- Fetches LED matrix frame data row by row from shared pixel RAM.
- Acts as one read-only requester port on the memory arbiter: issues read addresses and counts returned words.
- Streams pixels to the row driver and holds each row until the driver acknowledges it.
- Double-buffers frames: two base addresses, swap applied only at a frame boundary.

---
 rtl/frame_scan_sequencer.sv | 152 +++++++++++++++
 tb/tb_frame_scan_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_sequencer.sv
// LED matrix row fetcher: reads each row of a double-buffered frame from pixel RAM
// through one read-only arbiter port and streams it to the row driver.
module frame_scan_sequencer #(
   parameter int ADDRESS_WIDTH   = 25,
   parameter int DATA_WIDTH      = 16,
   parameter int COLS            = 64,
   parameter int ROWS            = 32,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      swap_req,
   input  logic [ADDRESS_WIDTH-1:0]  base_addr_0,
   input  logic [ADDRESS_WIDTH-1:0]  base_addr_1,
   output logic [ADDRESS_WIDTH-1:0]  mem_address,
   output logic                      mem_wr,
   output logic                      mem_req,
   input  logic                      mem_fifo_full,
   input  logic [DATA_WIDTH-1:0]     mem_data,
   input  logic                      mem_data_ready,
   output logic [DATA_WIDTH-1:0]     pix_data,
   output logic                      pix_valid,
   output logic [$clog2(COLS)-1:0]   pix_col,
   output logic [$clog2(ROWS)-1:0]   pix_row,
   output logic                      row_done,
   input  logic                      row_ack,
   output logic                      frame_done,
   output logic                      active_buffer,
   output logic                      busy,
   output logic                      resp_err
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int CNT_W = $clog2(COLS + 1);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_ACK} state_t;

   state_t                   state_q;
   logic [ADDRESS_WIDTH-1:0] row_base_q;
   logic [CNT_W-1:0]         issued_q;
   logic [CNT_W-1:0]         received_q;
   logic [OUT_W-1:0]         outstanding_q;
   logic [ROW_W-1:0]         row_q;
   logic                     swap_pending_q;
   logic                     active_buffer_q;
   logic                     resp_err_q;
   logic                     pix_valid_q;
   logic                     row_done_q;
   logic                     frame_done_q;
   logic [DATA_WIDTH-1:0]    pix_data_q;
   logic [COL_W-1:0]         pix_col_q;

   logic accept;
   logic resp_ok;

   assign mem_req = (state_q == FETCH) &&
                    (issued_q < CNT_W'(COLS)) &&
                    (outstanding_q < OUT_W'(MAX_OUTSTANDING));
   assign accept  = mem_req && !mem_fifo_full;
   // A response with nothing in flight is a protocol error and is discarded.
   assign resp_ok = mem_data_ready && (outstanding_q != '0);

   assign mem_address   = row_base_q + ADDRESS_WIDTH'(issued_q);
   assign mem_wr        = 1'b0;
   assign pix_data      = pix_data_q;
   assign pix_valid     = pix_valid_q;
   assign pix_col       = pix_col_q;
   assign pix_row       = row_q;
   assign row_done      = row_done_q;
   assign frame_done    = frame_done_q;
   assign active_buffer = active_buffer_q;
   assign busy          = (state_q != IDLE);
   assign resp_err      = resp_err_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         row_base_q      <= '0;
         issued_q        <= '0;
         received_q      <= '0;
         outstanding_q   <= '0;
         row_q           <= '0;
         swap_pending_q  <= 1'b0;
         active_buffer_q <= 1'b0;
         resp_err_q      <= 1'b0;
         pix_valid_q     <= 1'b0;
         row_done_q      <= 1'b0;
         frame_done_q    <= 1'b0;
         pix_data_q      <= '0;
         pix_col_q       <= '0;
      end else begin
         pix_valid_q    <= 1'b0;
         row_done_q     <= 1'b0;
         frame_done_q   <= 1'b0;
         swap_pending_q <= swap_pending_q | swap_req;
         outstanding_q  <= outstanding_q + OUT_W'(accept) - OUT_W'(resp_ok);

         if (accept)
            issued_q <= issued_q + CNT_W'(1);
         if (mem_data_ready && !resp_ok)
            resp_err_q <= 1'b1;

         if (resp_ok) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= mem_data;
            pix_col_q   <= received_q[COL_W-1:0];
            received_q  <= received_q + CNT_W'(1);
            if (received_q == CNT_W'(COLS - 1)) begin
               row_done_q <= 1'b1;
               state_q    <= WAIT_ACK;
            end
         end

         case (state_q)
            IDLE: begin
               // The frame_done cycle itself still belongs to the finished frame.
               if (start && !frame_done_q) begin
                  row_base_q <= active_buffer_q ? base_addr_1 : base_addr_0;
                  issued_q   <= '0;
                  received_q <= '0;
                  row_q      <= '0;
                  state_q    <= FETCH;
               end
            end
            WAIT_ACK: begin
               if (row_ack) begin
                  if (row_q != ROW_W'(ROWS - 1)) begin
                     row_q      <= row_q + ROW_W'(1);
                     row_base_q <= row_base_q + ADDRESS_WIDTH'(COLS);
                     issued_q   <= '0;
                     received_q <= '0;
                     state_q    <= FETCH;
                  end else begin
                     frame_done_q <= 1'b1;
                     state_q      <= IDLE;
                     // A swap_req landing on the toggle cycle stays pending for the next frame.
                     if (swap_pending_q) begin
                        active_buffer_q <= ~active_buffer_q;
                        swap_pending_q  <= swap_req;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_scan_sequencer.sv
// Scoreboard bench for frame_scan_sequencer: a memory model answers accepted reads
// and checks every address and returned pixel against queued expectations.
module tb_frame_scan_sequencer;

   localparam int AW   = 25;
   localparam int DW   = 16;
   localparam int COLS = 4;
   localparam int ROWS = 2;
   localparam int MAXO = 2;
   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(ROWS);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          swap_req = 1'b0;
   logic [AW-1:0] base_addr_0 = 25'h100;
   logic [AW-1:0] base_addr_1 = 25'h800;
   logic [AW-1:0] mem_address;
   logic          mem_wr;
   logic          mem_req;
   logic          mem_fifo_full = 1'b0;
   logic [DW-1:0] mem_data = '0;
   logic          mem_data_ready = 1'b0;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic [CW-1:0] pix_col;
   logic [RW-1:0] pix_row;
   logic          row_done;
   logic          row_ack = 1'b0;
   logic          frame_done;
   logic          active_buffer;
   logic          busy;
   logic          resp_err;

   frame_scan_sequencer #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .swap_req(swap_req),
      .base_addr_0(base_addr_0), .base_addr_1(base_addr_1),
      .mem_address(mem_address), .mem_wr(mem_wr), .mem_req(mem_req),
      .mem_fifo_full(mem_fifo_full), .mem_data(mem_data), .mem_data_ready(mem_data_ready),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row),
      .row_done(row_done), .row_ack(row_ack), .frame_done(frame_done),
      .active_buffer(active_buffer), .busy(busy), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_pix_q[$];
   logic [CW-1:0] exp_col_q[$];
   logic [RW-1:0] exp_row_q[$];
   logic [DW-1:0] ret_data_q[$];
   int            ret_due_q[$];

   int cyc = 0, lat = 1, model_out = 0, peak_out = 0, acc_total = 0;
   int rows_seen = 0, frames_seen = 0, same_cycle = 0, frame_acc = 0;
   bit waiting = 0, stray = 0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return a[DW-1:0] ^ 16'hC3A5;
   endfunction

   // Memory model and output scoreboard, sampled mid-cycle.
   initial begin
      forever begin
         logic          ret_real;
         logic          acc;
         logic [DW-1:0] e;
         logic [CW-1:0] c;
         logic [RW-1:0] r;
         logic [AW-1:0] a;
         @(negedge clk); #2;
         cyc++;
         if (!reset_n) begin
            exp_addr_q.delete(); exp_pix_q.delete(); exp_col_q.delete(); exp_row_q.delete();
            ret_data_q.delete(); ret_due_q.delete();
            model_out = 0; waiting = 0; stray = 0; mem_data_ready = 1'b0;
            continue;
         end
         if (pix_valid) begin
            vectors++;
            if (exp_pix_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_pixel data=%h col=%0d (no pixel expected)", pix_data, pix_col);
            end else begin
               e = exp_pix_q.pop_front(); c = exp_col_q.pop_front(); r = exp_row_q.pop_front();
               if (pix_data !== e || pix_col !== c || pix_row !== r || row_done !== (c == CW'(COLS-1))) begin
                  miscompares++;
                  $display("FAIL pixel got data=%h col=%0d row=%0d row_done=%b want data=%h col=%0d row=%0d row_done=%b",
                           pix_data, pix_col, pix_row, row_done, e, c, r, (c == CW'(COLS-1)));
               end
               if (c == CW'(COLS-1)) begin
                  rows_seen++;
                  waiting = 1;
               end
            end
         end else if (row_done) begin
            vectors++; miscompares++;
            $display("FAIL row_done_alone got row_done=1 want 0 without pix_valid");
         end
         if (frame_done) frames_seen++;
         if (waiting) begin
            vectors++;
            if (mem_req !== 1'b0) begin
               miscompares++;
               $display("FAIL req_in_wait_ack got mem_req=%b want 0", mem_req);
            end
            if (row_ack) waiting = 0;
         end
         ret_real = 1'b0;
         if (stray) begin
            mem_data_ready = 1'b1; mem_data = 16'hDEAD; stray = 0;
         end else if (ret_due_q.size() != 0 && ret_due_q[0] <= cyc) begin
            mem_data_ready = 1'b1; mem_data = ret_data_q.pop_front();
            void'(ret_due_q.pop_front());
            ret_real = 1'b1;
         end else begin
            mem_data_ready = 1'b0;
         end
         if (model_out == MAXO) begin
            vectors++;
            if (mem_req !== 1'b0) begin
               miscompares++;
               $display("FAIL req_at_max got mem_req=%b want 0 (outstanding=%0d)", mem_req, model_out);
            end
         end
         acc = mem_req && !mem_fifo_full;
         if (acc) begin
            vectors++;
            if (exp_addr_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_request addr=%h (no request expected)", mem_address);
            end else begin
               a = exp_addr_q.pop_front();
               if (mem_address !== a) begin
                  miscompares++;
                  $display("FAIL address got %h want %h", mem_address, a);
               end
               exp_pix_q.push_back(mem_word(a));
               exp_col_q.push_back(CW'(frame_acc % COLS));
               exp_row_q.push_back(RW'(frame_acc / COLS));
            end
            ret_data_q.push_back(mem_word(mem_address));
            ret_due_q.push_back(cyc + lat);
            acc_total++; frame_acc++;
            if (ret_real) same_cycle++;
         end
         model_out = model_out + int'(acc) - int'(ret_real);
         if (model_out > peak_out) peak_out = model_out;
         if (model_out > MAXO) begin
            vectors++; miscompares++;
            $display("FAIL outstanding got %0d want <= %0d", model_out, MAXO);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want $finish");
      $fatal(1, "watchdog");
   end

   task automatic push_frame(input logic [AW-1:0] base);
      frame_acc = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp_addr_q.push_back(base + AW'(r * COLS + c));
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic serve_frame(input int ack_delay, input bit poke_start, input bit swap_last);
      int r0, f0, t;
      r0 = rows_seen; f0 = frames_seen;
      for (int r = 0; r < ROWS; r++) begin
         t = 0;
         while (rows_seen < r0 + r + 1 && t < 300) begin @(negedge clk); t++; end
         if (rows_seen < r0 + r + 1) begin
            vectors++; miscompares++;
            $display("FAIL row_timeout got rows=%0d want %0d", rows_seen - r0, r + 1);
            return;
         end
         for (int d = 0; d < ack_delay; d++) begin
            @(negedge clk); start = poke_start && d[0];
         end
         @(negedge clk); start = 1'b0; row_ack = 1'b1; swap_req = swap_last && (r == ROWS-1);
         @(negedge clk); row_ack = 1'b0; swap_req = 1'b0;
      end
      t = 0;
      while (frames_seen < f0 + 1 && t < 50) begin @(negedge clk); t++; end
      if (frames_seen != f0 + 1) begin
         vectors++; miscompares++;
         $display("FAIL frame_done_count got %0d want 1", frames_seen - f0);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      vectors++;
      if ({mem_address, mem_wr, mem_req, pix_data, pix_valid, pix_col, pix_row, row_done,
           frame_done, active_buffer, busy, resp_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got addr=%h req=%b pix=%h valid=%b busy=%b err=%b want all 0",
                  mem_address, mem_req, pix_data, pix_valid, busy, resp_err);
      end
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int r0;
      r0 = rows_seen; lat = 1;
      push_frame(25'h100);
      pulse_start();
      serve_frame(1, 0, 0);
      vectors++;
      if (rows_seen - r0 != 2 || active_buffer !== 1'b0 || busy !== 1'b0 || exp_addr_q.size() != 0) begin
         miscompares++;
         $display("FAIL basic_frame got rows=%0d ab=%b busy=%b left=%0d want rows=2 ab=0 busy=0 left=0",
                  rows_seen - r0, active_buffer, busy, exp_addr_q.size());
      end
   endtask

   task automatic test_fifo_full();
      int a0, t;
      lat = 1; a0 = acc_total;
      push_frame(25'h100);
      pulse_start();
      t = 0;
      while (acc_total < a0 + 2 && t < 50) begin @(negedge clk); t++; end
      mem_fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #3;
         vectors++;
         if (mem_address !== 25'h102 || mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL fifo_full_hold got addr=%h req=%b want addr=102 req=1", mem_address, mem_req);
         end
         @(negedge clk);
      end
      mem_fifo_full = 1'b0;
      vectors++;
      if (acc_total != a0 + 2) begin
         miscompares++;
         $display("FAIL fifo_full_accepts got %0d want 2", acc_total - a0);
      end
      serve_frame(1, 0, 0);
   endtask

   task automatic test_outstanding();
      lat = 6; peak_out = 0; same_cycle = 0;
      push_frame(25'h100);
      pulse_start();
      serve_frame(1, 0, 0);
      vectors++;
      if (peak_out != MAXO || same_cycle == 0) begin
         miscompares++;
         $display("FAIL outstanding_peak got peak=%0d same_cycle=%0d want peak=%0d same_cycle>0",
                  peak_out, same_cycle, MAXO);
      end
      lat = 1;
   endtask

   task automatic test_swap();
      push_frame(25'h100);
      pulse_start();
      repeat (2) @(negedge clk);
      swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
      serve_frame(2, 0, 0);
      vectors++;
      if (active_buffer !== 1'b1) begin
         miscompares++;
         $display("FAIL swap_first got active_buffer=%b want 1", active_buffer);
      end
      push_frame(25'h800);
      pulse_start();
      repeat (2) @(negedge clk);
      swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
      serve_frame(1, 0, 1);
      vectors++;
      if (active_buffer !== 1'b0) begin
         miscompares++;
         $display("FAIL swap_second got active_buffer=%b want 0", active_buffer);
      end
      push_frame(25'h100);
      pulse_start();
      serve_frame(1, 0, 0);
      vectors++;
      if (active_buffer !== 1'b1) begin
         miscompares++;
         $display("FAIL swap_kept_pending got active_buffer=%b want 1", active_buffer);
      end
   endtask

   task automatic test_wait_ack();
      push_frame(25'h800);
      pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      serve_frame(20, 1, 0);
      vectors++;
      if (busy !== 1'b0 || exp_addr_q.size() != 0 || exp_pix_q.size() != 0) begin
         miscompares++;
         $display("FAIL wait_ack_frame got busy=%b addr_left=%0d pix_left=%0d want 0 0 0",
                  busy, exp_addr_q.size(), exp_pix_q.size());
      end
   endtask

   task automatic test_stray_and_reset();
      int a0, t;
      @(negedge clk); stray = 1;
      @(negedge clk); #3;
      vectors++;
      if (resp_err !== 1'b1 || pix_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_response got resp_err=%b pix_valid=%b want 1 0", resp_err, pix_valid);
      end
      a0 = acc_total;
      push_frame(25'h800);
      pulse_start();
      t = 0;
      while (acc_total < a0 + 2 && t < 50) begin @(negedge clk); t++; end
      reset_n = 1'b0;
      @(negedge clk); #3;
      vectors++;
      if ({mem_address, mem_wr, mem_req, pix_data, pix_valid, pix_col, pix_row, row_done,
           frame_done, active_buffer, busy, resp_err} !== '0) begin
         miscompares++;
         $display("FAIL midrow_reset got addr=%h req=%b pix=%h valid=%b ab=%b busy=%b err=%b want all 0",
                  mem_address, mem_req, pix_data, pix_valid, active_buffer, busy, resp_err);
      end
      @(negedge clk); reset_n = 1'b1;
      push_frame(25'h100);
      pulse_start();
      serve_frame(1, 0, 0);
      vectors++;
      if (active_buffer !== 1'b0 || resp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset got ab=%b err=%b want 0 0", active_buffer, resp_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fifo_full();
      test_outstanding();
      test_swap();
      test_wait_ack();
      test_stray_and_reset();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
